// File: rtl/axi_udp_rx.sv
// ============================================================================
//  Module   : axi_udp_rx
//  Purpose  : Parses byte-serial Ethernet II/ARP frames and requests a unicast
//             ARP reply from the transmitter when a request targets our IP.
//             Optional destination-MAC filter: AXI_UDP_RX_MAC_FILTER_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_udp_rx #(
    parameter logic [23:0] MAC_MSB = 24'h010203,
    parameter logic [23:0] MAC_LSB = 24'h040506,
    parameter logic [15:0] IP_MSB  = 16'hc0a8,
    parameter logic [15:0] IP_LSB  = 16'h0602
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        arp_start,
    output logic [15:0] arp_opcode,
    output logic [47:0] arp_dst_mac,
    output logic [31:0] arp_dst_ip
);

    localparam logic [31:0] MY_IP  = {IP_MSB, IP_LSB};

    typedef enum logic [0:0] {
        S_RECV = 1'b0,
        S_DROP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;
    logic        tready_q;
    logic [47:0] mac_sh_q, mac_sh_d;
    logic [31:0] ip_sh_q, ip_sh_d;
    logic        start_q, start_d;
    logic [15:0] opcode_q, opcode_d;
    logic [47:0] dst_mac_q, dst_mac_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic        w_beat;
    logic        w_fail;
    logic        w_accept;

`ifdef AXI_UDP_RX_MAC_FILTER_EN
    localparam logic [47:0] MY_MAC = {MAC_MSB, MAC_LSB};
    logic       bcast_q, bcast_d;
    logic       mine_q, mine_d;
    logic [7:0] w_mac_byte;
`endif

    assign w_beat = s_axis_tvalid & tready_q;

    // Per-byte header check; bytes not listed never fail.
    always_comb begin
        w_fail = 1'b0;
        case (idx_q)
            11'd12: w_fail = (s_axis_tdata != 8'h08);
            11'd13: w_fail = (s_axis_tdata != 8'h06);
            11'd14: w_fail = (s_axis_tdata != 8'h00);
            11'd15: w_fail = (s_axis_tdata != 8'h01);
            11'd16: w_fail = (s_axis_tdata != 8'h08);
            11'd17: w_fail = (s_axis_tdata != 8'h00);
            11'd18: w_fail = (s_axis_tdata != 8'h06);
            11'd19: w_fail = (s_axis_tdata != 8'h04);
            11'd20: w_fail = (s_axis_tdata != 8'h00);
            11'd21: w_fail = (s_axis_tdata != 8'h01);
            11'd38: w_fail = (s_axis_tdata != MY_IP[31:24]);
            11'd39: w_fail = (s_axis_tdata != MY_IP[23:16]);
            11'd40: w_fail = (s_axis_tdata != MY_IP[15:8]);
            11'd41: w_fail = (s_axis_tdata != MY_IP[7:0]);
            default: w_fail = 1'b0;
        endcase
`ifdef AXI_UDP_RX_MAC_FILTER_EN
        case (idx_q)
            11'd0:   w_mac_byte = MY_MAC[47:40];
            11'd1:   w_mac_byte = MY_MAC[39:32];
            11'd2:   w_mac_byte = MY_MAC[31:24];
            11'd3:   w_mac_byte = MY_MAC[23:16];
            11'd4:   w_mac_byte = MY_MAC[15:8];
            default: w_mac_byte = MY_MAC[7:0];
        endcase
        // Flags restart at byte 0 so each frame is judged on its own bytes.
        bcast_d = bcast_q;
        mine_d  = mine_q;
        if (idx_q < 11'd6) begin
            bcast_d = ((idx_q == 11'd0) | bcast_q) & (s_axis_tdata == 8'hff);
            mine_d  = ((idx_q == 11'd0) | mine_q) & (s_axis_tdata == w_mac_byte);
            if (!(bcast_d | mine_d))
                w_fail = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mac_sh_d  = mac_sh_q;
        ip_sh_d   = ip_sh_q;
        w_accept  = 1'b0;
        if (w_beat) begin
            if (s_axis_tlast)
                idx_d = 11'd0;
            else if (idx_q != 11'd2047)
                idx_d = idx_q + 11'd1;

            if (idx_q >= 11'd22 && idx_q <= 11'd27)
                mac_sh_d = {mac_sh_q[39:0], s_axis_tdata};
            if (idx_q >= 11'd28 && idx_q <= 11'd31)
                ip_sh_d = {ip_sh_q[23:0], s_axis_tdata};

            case (state_q)
                S_RECV: begin
                    if (s_axis_tlast)
                        w_accept = ~w_fail & (idx_q >= 11'd41);
                    else if (w_fail)
                        state_d = S_DROP;
                end
                default: begin
                    if (s_axis_tlast)
                        state_d = S_RECV;
                end
            endcase
        end
    end

    // Outputs load only on accept so later shadow updates cannot disturb them.
    always_comb begin
        start_d   = w_accept;
        opcode_d  = opcode_q;
        dst_mac_d = dst_mac_q;
        dst_ip_d  = dst_ip_q;
        if (w_accept) begin
            opcode_d  = 16'h0002;
            dst_mac_d = mac_sh_q;
            dst_ip_d  = ip_sh_q;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_RECV;
            idx_q     <= 11'd0;
            tready_q  <= 1'b0;
            mac_sh_q  <= 48'd0;
            ip_sh_q   <= 32'd0;
            start_q   <= 1'b0;
            opcode_q  <= 16'd0;
            dst_mac_q <= 48'd0;
            dst_ip_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tready_q  <= 1'b1;
            mac_sh_q  <= mac_sh_d;
            ip_sh_q   <= ip_sh_d;
            start_q   <= start_d;
            opcode_q  <= opcode_d;
            dst_mac_q <= dst_mac_d;
            dst_ip_q  <= dst_ip_d;
        end
    end

`ifdef AXI_UDP_RX_MAC_FILTER_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bcast_q <= 1'b0;
            mine_q  <= 1'b0;
        end else if (w_beat) begin
            bcast_q <= bcast_d;
            mine_q  <= mine_d;
        end
    end
`endif

    assign s_axis_tready = tready_q;
    assign arp_start     = start_q;
    assign arp_opcode    = opcode_q;
    assign arp_dst_mac   = dst_mac_q;
    assign arp_dst_ip    = dst_ip_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_udp_rx.sv
// ============================================================================
//  Module   : tb_axi_udp_rx
//  Purpose  : Directed self-checking bench for axi_udp_rx ARP request parsing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_udp_rx;

    logic        clk;
    logic        aresetn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        arp_start;
    logic [15:0] arp_opcode;
    logic [47:0] arp_dst_mac;
    logic [31:0] arp_dst_ip;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [7:0] fr [0:63];

`ifdef AXI_UDP_RX_MAC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    localparam logic [47:0] BCAST = 48'hffffffffffff;
    localparam logic [31:0] TIP   = 32'hc0a80602;

    axi_udp_rx dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .arp_start     (arp_start),
        .arp_opcode    (arp_opcode),
        .arp_dst_mac   (arp_dst_mac),
        .arp_dst_ip    (arp_dst_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (arp_start === 1'b1)
            pulses <= pulses + 1;

    task automatic build(input logic [47:0] dst, input logic [15:0] et,
                         input logic [15:0] op, input logic [47:0] smac,
                         input logic [31:0] sip, input logic [31:0] tip);
        for (int i = 0; i < 64; i++) fr[i] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            fr[k]      = dst[47-8*k -: 8];
            fr[6+k]    = 8'h0a + 8'(k);
            fr[22+k]   = smac[47-8*k -: 8];
        end
        fr[12] = et[15:8];  fr[13] = et[7:0];
        fr[14] = 8'h00;     fr[15] = 8'h01;
        fr[16] = 8'h08;     fr[17] = 8'h00;
        fr[18] = 8'h06;     fr[19] = 8'h04;
        fr[20] = op[15:8];  fr[21] = op[7:0];
        for (int k = 0; k < 4; k++) begin
            fr[28+k] = sip[31-8*k -: 8];
            fr[38+k] = tip[31-8*k -: 8];
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        if (gap > 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_range(input int first, input int last_idx, input bit tl, input int maxgap);
        for (int i = first; i <= last_idx; i++)
            send_byte(fr[i], tl && (i == last_idx), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
        checks++; if (arp_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", arp_start); end
        checks++; if (arp_opcode !== 16'h0 || arp_dst_mac !== 48'h0 || arp_dst_ip !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: got %h %h %h expected all zero", arp_opcode, arp_dst_mac, arp_dst_ip); end
        aresetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b expected 1", s_axis_tready); end
        repeat (3) @(posedge clk); #1;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_no_pulse: got %0d expected 0", pulses); end
    endtask

    task automatic test_broadcast();
        int p0 = pulses;
        build(BCAST, 16'h0806, 16'h0001, 48'h001122334455, 32'hc0a80601, TIP);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b1) begin errors++; $display("FAIL bc_start: got %b expected 1", arp_start); end
        checks++; if (arp_dst_mac !== 48'h001122334455) begin errors++; $display("FAIL bc_mac: got %h expected 001122334455", arp_dst_mac); end
        checks++; if (arp_dst_ip !== 32'hc0a80601) begin errors++; $display("FAIL bc_ip: got %h expected c0a80601", arp_dst_ip); end
        checks++; if (arp_opcode !== 16'h0002) begin errors++; $display("FAIL bc_opcode: got %h expected 0002", arp_opcode); end
        @(posedge clk); #1;
        checks++; if (arp_start !== 1'b0) begin errors++; $display("FAIL bc_one_cycle: got %b expected 0", arp_start); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL bc_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_padded_gaps();
        int p0 = pulses;
        build(BCAST, 16'h0806, 16'h0001, 48'h001122334455, 32'hc0a80601, TIP);
        send_range(0, 58, 1'b0, 3);
        checks++; if (pulses - p0 !== 0 || arp_start !== 1'b0) begin
            errors++; $display("FAIL pad_early_pulse: got %0d pulses expected 0", pulses - p0); end
        send_range(59, 59, 1'b1, 2);
        checks++; if (arp_start !== 1'b1) begin errors++; $display("FAIL pad_start: got %b expected 1", arp_start); end
        checks++; if (arp_dst_mac !== 48'h001122334455 || arp_dst_ip !== 32'hc0a80601) begin
            errors++; $display("FAIL pad_addr: got %h/%h expected 001122334455/c0a80601", arp_dst_mac, arp_dst_ip); end
        @(posedge clk); #1;
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL pad_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_rejects();
        int p0 = pulses;
        build(BCAST, 16'h0806, 16'h0001, 48'hdeadbeef0001, 32'h0a000001, 32'hc0a80603);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b0) begin errors++; $display("FAIL rej_tip_start: got %b expected 0", arp_start); end
        build(BCAST, 16'h0806, 16'h0002, 48'hdeadbeef0002, 32'h0a000002, TIP);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b0) begin errors++; $display("FAIL rej_op_start: got %b expected 0", arp_start); end
        build(BCAST, 16'h0800, 16'h0001, 48'hdeadbeef0003, 32'h0a000003, TIP);
        send_range(0, 45, 1'b1, 0);
        checks++; if (arp_start !== 1'b0) begin errors++; $display("FAIL rej_et_start: got %b expected 0", arp_start); end
        checks++; if (arp_dst_mac !== 48'h001122334455 || arp_dst_ip !== 32'hc0a80601 || arp_opcode !== 16'h0002) begin
            errors++; $display("FAIL rej_hold: got %h/%h/%h expected 001122334455/c0a80601/0002", arp_dst_mac, arp_dst_ip, arp_opcode); end
        build(BCAST, 16'h0806, 16'h0001, 48'h665544332211, 32'hc0a80605, TIP);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b1 || arp_dst_mac !== 48'h665544332211 || arp_dst_ip !== 32'hc0a80605) begin
            errors++; $display("FAIL rej_next_accept: got %b %h %h expected 1 665544332211 c0a80605", arp_start, arp_dst_mac, arp_dst_ip); end
        @(posedge clk); #1;
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL rej_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_runt();
        int p0 = pulses;
        build(BCAST, 16'h0806, 16'h0001, 48'h0000000000aa, 32'h0a0000aa, TIP);
        send_range(0, 30, 1'b1, 0);
        checks++; if (arp_start !== 1'b0 || arp_dst_mac !== 48'h665544332211) begin
            errors++; $display("FAIL runt_ignored: got %b %h expected 0 665544332211", arp_start, arp_dst_mac); end
        build(BCAST, 16'h0806, 16'h0001, 48'h0000000000bb, 32'hc0a806bb, TIP);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b1 || arp_dst_mac !== 48'h0000000000bb || arp_dst_ip !== 32'hc0a806bb) begin
            errors++; $display("FAIL runt_next_accept: got %b %h %h expected 1 0000000000bb c0a806bb", arp_start, arp_dst_mac, arp_dst_ip); end
        @(posedge clk); #1;
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL runt_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        build(BCAST, 16'h0806, 16'h0001, 48'h1111111111c1, 32'hc0a806c1, TIP);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b1 || arp_dst_mac !== 48'h1111111111c1) begin
            errors++; $display("FAIL b2b_first: got %b %h expected 1 1111111111c1", arp_start, arp_dst_mac); end
        build(BCAST, 16'h0806, 16'h0001, 48'h2222222222c2, 32'hc0a806c2, TIP);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b1 || arp_dst_mac !== 48'h2222222222c2 || arp_dst_ip !== 32'hc0a806c2) begin
            errors++; $display("FAIL b2b_second: got %b %h %h expected 1 2222222222c2 c0a806c2", arp_start, arp_dst_mac, arp_dst_ip); end
        @(posedge clk); #1;
        checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0); end
    endtask

    task automatic test_mac_filter();
        int p0 = pulses;
        logic [47:0] exp_mac;
        build(48'h010203040506, 16'h0806, 16'h0001, 48'h3333333333d1, 32'hc0a806d1, TIP);
        send_range(0, 41, 1'b1, 0);
        checks++; if (arp_start !== 1'b1 || arp_dst_mac !== 48'h3333333333d1) begin
            errors++; $display("FAIL mac_own_accept: got %b %h expected 1 3333333333d1", arp_start, arp_dst_mac); end
        build(48'h010203040507, 16'h0806, 16'h0001, 48'h4444444444d2, 32'hc0a806d2, TIP);
        send_range(0, 41, 1'b1, 0);
        exp_mac = FILTER ? 48'h3333333333d1 : 48'h4444444444d2;
        checks++; if (arp_start !== !FILTER || arp_dst_mac !== exp_mac) begin
            errors++; $display("FAIL mac_other: got %b %h expected %b %h", arp_start, arp_dst_mac, !FILTER, exp_mac); end
        @(posedge clk); #1;
        checks++; if (pulses - p0 !== (FILTER ? 1 : 2)) begin
            errors++; $display("FAIL mac_pulses: got %0d expected %0d", pulses - p0, FILTER ? 1 : 2); end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_padded_gaps();
        test_rejects();
        test_runt();
        test_back_to_back();
        test_mac_filter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_udp_rx.md
Name: axi_udp_rx

Overview:
- Receive-side ARP responder front end. Consumes Ethernet frames byte-serially on an AXI4-Stream slave and parses Ethernet II + ARP headers.
- On a valid ARP request for our IP, drives the transmitter's request interface (arp_start, arp_opcode, arp_dst_mac, arp_dst_ip) so the transmitter emits a unicast ARP reply.
- Sits between the MAC RX byte stream and axi_udp_tx.

Parameters:
- MAC_MSB, 24'h010203, upper 3 bytes of local MAC
- MAC_LSB, 24'h040506, lower 3 bytes of local MAC
- IP_MSB, 16'hc0a8, upper 2 bytes of local IPv4 address
- IP_LSB, 16'h0602, lower 2 bytes of local IPv4 address

Ports:
- clk  input  1  single clock, rising edge
- aresetn  input  1  asynchronous active-low reset
- s_axis_tdata  input  8  frame byte, first byte = dst MAC[47:40]
- s_axis_tvalid  input  1  byte valid
- s_axis_tlast  input  1  last byte of frame (FCS already stripped or ignored)
- s_axis_tready  output  1  ready
- arp_start  output  1  one-cycle request pulse to TX
- arp_opcode  output  16  opcode for TX; always 16'h0002 on a request
- arp_dst_mac  output  48  requester's sender hardware address
- arp_dst_ip  output  32  requester's sender protocol address

Behaviour:
- Reset (asynchronous on aresetn low): all outputs 0, s_axis_tready 0, state RECV, byte index 0. s_axis_tready goes to 1 on the first clk edge after release and stays 1; the block never back-pressures.
- Beat = s_axis_tvalid & s_axis_tready. Byte index is 11 bits, increments per beat, saturates at 2047, clears to 0 on a tlast beat.
- Byte map (index: check/capture):
  - 0-5: dst MAC (see optional feature)
  - 6-11: ignored
  - 12-13: must be 08 06
  - 14-15: must be 00 01
  - 16-17: must be 08 00
  - 18: must be 06
  - 19: must be 04
  - 20-21: must be 00 01 (request)
  - 22-27: capture sender MAC into shadow register
  - 28-31: capture sender IP into shadow register
  - 32-37: ignored
  - 38-41: must equal MY_IP ({IP_MSB,IP_LSB})
  - ≥42: ignored (padding/FCS)
- States:
  - RECV: any check failure → DROP.
  - DROP: ignore beats until a tlast beat, then return to RECV with index 0.
  - A tlast beat in RECV with index < 41 (runt) → back to RECV, no output.
  - Frame accepted iff still in RECV at the tlast beat and index ≥ 41 at that beat. The index-41 check must pass; this includes a frame whose tlast lands exactly on byte 41.
- Accept action, on the cycle after the accepting tlast beat:
  - arp_start = 1 for exactly one cycle.
  - arp_dst_mac and arp_dst_ip load from the shadow registers; arp_opcode = 16'h0002.
  - These outputs then hold until the next accepted frame. Shadow registers updating during a later frame must not disturb them.
- Rejected or runt frames never modify arp_* outputs and never pulse arp_start.
- Back-to-back frames: byte 0 of the next frame may arrive in the cycle right after tlast. Parsing restarts cleanly. A second accept may pulse arp_start on consecutive frames with no gap requirement. TX drops starts while busy; that is acceptable.
- tvalid gaps (tvalid low) freeze all parse state.
- Reset mid-frame: state returns to RECV, index 0. Remaining bytes of the interrupted frame are parsed as a new frame and fail the ethertype/opcode checks in normal traffic.

Optional Feature:
- Macro: AXI_UDP_RX_MAC_FILTER_EN.
- Defined: bytes 0-5 must equal ff:ff:ff:ff:ff:ff or MY_MAC ({MAC_MSB,MAC_LSB}); a mismatch → DROP. Each byte is checked against both candidates, tracked with two match flags.
- Undefined: bytes 0-5 are ignored and no flag logic is built.

Test Plan:
- Reset release → s_axis_tready 0 during reset, 1 one cycle later; all arp_* 0, arp_start never pulses.
- Broadcast request (dst ff×6, sender MAC 00:11:22:33:44:55, sender IP c0a80601, target IP c0a80602), 42 bytes, tlast on byte 41 → one-cycle arp_start one cycle after tlast beat; arp_dst_mac=001122334455, arp_dst_ip=c0a80601, arp_opcode=0002.
- Same request padded to 60 bytes with random tvalid gaps → identical single pulse after byte 59's tlast beat; no pulse earlier.
- Target IP c0a80603, or opcode 0002, or ethertype 0800 → no arp_start; outputs keep previous values; a following valid frame back-to-back is accepted.
- Runt: tlast on byte 30 of an otherwise valid request → no pulse; next valid frame accepted normally.
- With AXI_UDP_RX_MAC_FILTER_EN: dst 01:02:03:04:05:06 → accepted; dst 01:02:03:04:05:07 → dropped. Without the macro, the dst 01:02:03:04:05:07 frame is accepted.
